display_mux_nseg: RTL and testbench
===================================

Name: display_mux_nseg

Overview:
- Time-multiplexed driver for N common-pin 7-segment digits sharing one segment bus, plus decimal point.
- Parametrised successor to the two-digit alternating display driver. Adds an internal refresh divider, per-digit enable with skipping, anti-ghosting blank time, selectable output polarity and a frame pulse.
- Sits between the value/decoder logic and the board display pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (>= 2)
REFRESH_DIV, 1000, clk cycles per digit slot (> BLANK_CYCLES + 1)
BLANK_CYCLES, 2, cycles at start of each slot with all digits and segments off
SEG_ACTIVE_LOW, 0, 1 = seg/dp pins active low
DIG_ACTIVE_LOW, 0, 1 = dig pins active low

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
on_off  in  1  display enable; 0 = dark, scan held
seg_in  in  7*N_DIGITS  segments a..g per digit; digit k at [7k+6:7k], bit 0 = a
dp_in  in  N_DIGITS  decimal point per digit
digit_en  in  N_DIGITS  1 = digit participates in scan
dig  out  N_DIGITS  digit select, one-hot active when lit
seg  out  7  shared segment bus a..g
dp  out  1  shared decimal point
slot  out  max(1,clog2(N_DIGITS))  index of digit owning current slot
frame_tick  out  1  one-cycle pulse at start of each new scan frame

Behaviour:
- Reset (async assert, sync release): cnt=0, slot=0, latched data=0, frame_tick=0.
- Reset: dig/seg/dp at inactive level (all 0, or all 1 where the ACTIVE_LOW parameter is set).
- Slot counter cnt runs 0..REFRESH_DIV-1 while on_off=1. At cnt=REFRESH_DIV-1 it wraps to 0 and a slot boundary occurs.
- At a boundary, slot advances to the next index above the current one, circularly, with digit_en=1.
  - If no other digit is enabled and the current one is, slot stays.
  - If no digit is enabled, slot stays and outputs remain dark.
- frame_tick=1 for the single cycle after a boundary where new slot <= old slot (wrap). With one enabled digit it pulses every slot.
- Data latch: seg_in/dp_in of the new slot are captured at the boundary. Input changes mid-slot are not shown until that digit's next slot; no tearing.
- Lit condition: on_off=1, cnt >= BLANK_CYCLES, digit_en[slot]=1 (live value).
  - When lit: dig = one-hot(slot), seg/dp = latched data.
  - Otherwise: all outputs inactive.
- Polarity is applied last. Internally 1 = on. seg/dp are inverted when SEG_ACTIVE_LOW=1; dig is inverted when DIG_ACTIVE_LOW=1.
- All outputs are registered: one cycle from internal state to pins.
- Never more than one dig active in any cycle, including across boundaries and enable changes.
- Clearing digit_en of the current slot darkens it on the next cycle; the scan advances at the normal boundary.
- on_off=0: cnt, slot and frame_tick held at 0 (frame_tick forced 0); outputs inactive.
  - on_off 0->1: scan restarts at cnt=0, slot 0 if enabled, else the first enabled above 0. Data is latched on that cycle.
- Reset mid-slot: outputs go inactive immediately (asynchronous); the scan restarts as at reset.

Test Plan:
1. N=4, DIV=8, BLANK=2, all enabled, seg_in digit k = k+1 pattern, on_off=1:
   - dig walks 0001->0010->0100->1000->0001.
   - Each digit lit 6 of 8 cycles, seg matches digit.
   - frame_tick once per 32 cycles at slot 0.
2. digit_en=4'b1010:
   - slot alternates 1,3; digits 0 and 2 never lit.
   - frame_tick at each return to slot 1.
   - digit_en=0000: all dark, slot frozen.
3. Change seg_in[6:0] mid-slot of digit 0:
   - seg unchanged until digit 0's next slot, then shows the new value.
4. SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1:
   - Reset and blank cycles give dig=1111, seg=1111111, dp=1.
   - Lit pattern 0x3F on digit 2 gives seg=1000000, dig=1011.
5. Drop on_off mid-slot:
   - Outputs inactive next cycle, slot=0.
   - Re-raise: first lit at cnt=BLANK (3 cycles incl. register) on slot 0.
6. Assert rst_n=0 during lit slot 3:
   - Outputs inactive without a clock edge.
   - After release, scan starts at slot 0.
   - One-hot check on dig holds throughout.

Source files
------------

// File: rtl/display_mux_nseg.sv
// Time-multiplexed driver for N common-pin 7-segment digits on a shared segment bus.
// Each digit owns a slot of REFRESH_DIV cycles, the first BLANK_CYCLES of which are dark.
module display_mux_nseg #(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0,
    localparam int SLOT_W        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    on_off,
    input  logic [7*N_DIGITS-1:0]   seg_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     digit_en,
    output logic [N_DIGITS-1:0]     dig,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [SLOT_W-1:0]       slot,
    output logic                    frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 2;
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [SLOT_W:0]     N_WIDE    = (SLOT_W + 1)'(N_DIGITS);
    localparam logic [N_DIGITS-1:0] ONE_HOT0  = {{(N_DIGITS - 1){1'b0}}, 1'b1};

    // Handshake-free block: inputs are sampled every clock, outputs are registered levels.
    typedef enum logic {
        ST_DARK = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 start;
    logic                 boundary;
    logic                 lit;
    logic [CNT_W-1:0]     cnt;
    logic [SLOT_W-1:0]    slot_nxt;
    logic [SLOT_W:0]      k;
    logic [6:0]           seg_lat;
    logic                 dp_lat;
    logic [6:0]           seg_sel;
    logic                 dp_sel;
    logic                 frame_nxt;
    logic [N_DIGITS-1:0]  dig_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_DARK;
        end else begin
            state <= state_nxt;
        end
    end

    // Leaving ST_DARK is a restart: it behaves like a slot boundary that searches from digit 0.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            ST_DARK: begin
                if (on_off) begin
                    state_nxt = ST_SCAN;
                    start     = 1'b1;
                end
            end
            ST_SCAN: begin
                if (!on_off) begin
                    state_nxt = ST_DARK;
                end
            end
            default: state_nxt = ST_DARK;
        endcase
    end

    assign boundary = on_off && (start || ((state == ST_SCAN) && (cnt == CNT_LAST)));

    // Next enabled digit: circular search strictly above the current slot, or from 0 on restart.
    always_comb begin
        slot_nxt = slot;
        k        = '0;
        if (start) begin
            slot_nxt = '0;
            for (int i = N_DIGITS - 1; i >= 0; i--) begin
                if (digit_en[i]) begin
                    slot_nxt = SLOT_W'(i);
                end
            end
        end else begin
            for (int i = N_DIGITS - 1; i >= 1; i--) begin
                k = {1'b0, slot} + (SLOT_W + 1)'(i);
                if (k >= N_WIDE) begin
                    k = k - N_WIDE;
                end
                if (digit_en[k[SLOT_W-1:0]]) begin
                    slot_nxt = k[SLOT_W-1:0];
                end
            end
        end
    end

    always_comb begin
        seg_sel = '0;
        dp_sel  = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (slot_nxt == SLOT_W'(i)) begin
                seg_sel = seg_in[7*i +: 7];
                dp_sel  = dp_in[i];
            end
        end
    end

    // No frame pulse when nothing is enabled: there is no frame to mark.
    assign frame_nxt = boundary && (|digit_en) && (start || (slot_nxt <= slot));

    // Live digit_en gating makes a disabled digit go dark on the very next cycle.
    assign lit    = (state == ST_SCAN) && on_off && (cnt >= CNT_BLANK) && digit_en[slot];
    assign dig_on = lit ? (ONE_HOT0 << slot) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            slot       <= '0;
            seg_lat    <= '0;
            dp_lat     <= 1'b0;
            frame_tick <= 1'b0;
            dig        <= {N_DIGITS{DIG_ACTIVE_LOW}};
            seg        <= {7{SEG_ACTIVE_LOW}};
            dp         <= SEG_ACTIVE_LOW;
        end else begin
            dig        <= dig_on ^ {N_DIGITS{DIG_ACTIVE_LOW}};
            seg        <= (lit ? seg_lat : 7'd0) ^ {7{SEG_ACTIVE_LOW}};
            dp         <= (lit & dp_lat) ^ SEG_ACTIVE_LOW;
            frame_tick <= frame_nxt;
            if (!on_off) begin
                cnt  <= '0;
                slot <= '0;
            end else begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
                if (boundary) begin
                    slot    <= slot_nxt;
                    seg_lat <= seg_sel;
                    dp_lat  <= dp_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_display_mux_nseg.sv
// Bench for display_mux_nseg: two instances (active-high and active-low pins) share stimulus
// and are compared every cycle against a slot-level behavioural model.
module tb_display_mux_nseg;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int EW    = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        on_off = 1'b0;
    logic [27:0] seg_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;

    logic [3:0]  dig_a, dig_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [1:0]  slot_a, slot_b;
    logic        frame_a, frame_b;

    int checks = 0;
    int errors = 0;

    // model state: cycle counter, owning digit, running flag, latched digit data
    int          m_cnt, m_slot;
    bit          m_run;
    logic [6:0]  m_seg;
    logic        m_dp;
    logic [3:0]  e_dig;
    logic [6:0]  e_seg;
    logic        e_dp, e_frame;
    logic [EW-1:0] exp_q[$];

    display_mux_nseg #(.N_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK),
                       .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .on_off(on_off), .seg_in(seg_in), .dp_in(dp_in),
        .digit_en(digit_en), .dig(dig_a), .seg(seg_a), .dp(dp_a), .slot(slot_a),
        .frame_tick(frame_a));

    display_mux_nseg #(.N_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK),
                       .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .on_off(on_off), .seg_in(seg_in), .dp_in(dp_in),
        .digit_en(digit_en), .dig(dig_b), .seg(seg_b), .dp(dp_b), .slot(slot_b),
        .frame_tick(frame_b));

    // clock / watchdog
    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_slot  = 0;
        m_run   = 1'b0;
        m_seg   = '0;
        m_dp    = 1'b0;
        e_dig   = '0;
        e_seg   = '0;
        e_dp    = 1'b0;
        e_frame = 1'b0;
    endtask

    function automatic int next_slot(bit from_zero);
        if (from_zero) begin
            for (int d = 0; d < N; d++) if (digit_en[d]) return d;
            return 0;
        end
        for (int i = 1; i < N; i++) if (digit_en[(m_slot + i) % N]) return (m_slot + i) % N;
        return m_slot;
    endfunction

    // One clock edge of the display as seen at the pins.
    task automatic model_step();
        bit lit, restart, bnd;
        int ns;
        lit   = on_off && m_run && (m_cnt >= BLANK) && digit_en[m_slot];
        e_dig = lit ? 4'(1 << m_slot) : 4'd0;
        e_seg = lit ? m_seg : 7'd0;
        e_dp  = lit ? m_dp : 1'b0;
        e_frame = 1'b0;
        if (!on_off) begin
            m_cnt  = 0;
            m_slot = 0;
            m_run  = 1'b0;
        end else begin
            restart = !m_run;
            bnd     = restart || (m_cnt == DIV - 1);
            m_cnt   = (m_cnt + 1) % DIV;
            if (bnd) begin
                ns      = next_slot(restart);
                e_frame = (digit_en != 4'd0) && (restart || ns <= m_slot);
                m_slot  = ns;
                m_seg   = seg_in[7*m_slot +: 7];
                m_dp    = dp_in[m_slot];
            end
            m_run = 1'b1;
        end
    endtask

    task automatic compare();
        logic [EW-1:0] e;
        logic [3:0] ed, ed_n;
        logic [6:0] es, es_n;
        logic ep, ep_n, ef;
        logic [1:0] esl;
        check("exp_q_size", 32'(exp_q.size()), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        {ed, es, ep, esl, ef} = e;
        ed_n = ~ed;
        es_n = ~es;
        ep_n = ~ep;
        check("dig_a", dig_a, ed);
        check("seg_a", seg_a, es);
        check("dp_a", dp_a, ep);
        check("slot_a", slot_a, esl);
        check("frame_a", frame_a, ef);
        check("dig_b", dig_b, ed_n);
        check("seg_b", seg_b, es_n);
        check("dp_b", dp_b, ep_n);
        check("slot_b", slot_b, esl);
        check("frame_b", frame_b, ef);
        check("onehot_a", $countones(dig_a) <= 1, 1);
        check("onehot_b", $countones(~dig_b) <= 1, 1);
    endtask

    // driver: inputs change only at the falling edge, right after the compare
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        exp_q.push_back({e_dig, e_seg, e_dp, 2'(m_slot), e_frame});
        @(negedge clk);
        compare();
    endtask

    task automatic wait_model(input int s, input int c, input int budget);
        int n;
        n = 0;
        cycle();
        while (!(m_slot == s && m_cnt == c && m_run) && n < budget) begin
            cycle();
            n++;
        end
        check("wait_state", (m_slot == s && m_cnt == c && m_run), 1);
    endtask

    task automatic set_digit(input int d, input logic [6:0] v);
        seg_in[7*d +: 7] = v;
    endtask

    initial begin
        int lit_cnt[4];
        int frames, bad, n, s0;
        logic [6:0] old_v, new_v;

        // reset state, asynchronous assertion before any clock edge
        for (int d = 0; d < N; d++) set_digit(d, 7'(d + 1));
        dp_in    = 4'b0101;
        digit_en = 4'b1111;
        on_off   = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_dig_a", dig_a, 4'b0000);
        check("rst_seg_a", seg_a, 7'b0000000);
        check("rst_slot_a", slot_a, 0);
        check("rst_frame_a", frame_a, 0);
        check("rst_dig_b", dig_b, 4'b1111);
        check("rst_seg_b", seg_b, 7'b1111111);
        check("rst_dp_b", dp_b, 1);
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;

        // all digits enabled: each lit 6 of 8 cycles, one frame per 32
        repeat (8) cycle();
        for (int d = 0; d < N; d++) lit_cnt[d] = 0;
        frames = 0;
        for (int t = 0; t < 32; t++) begin
            cycle();
            frames += int'(frame_a);
            for (int d = 0; d < N; d++) if (dig_a == 4'(1 << d)) begin
                lit_cnt[d]++;
                check("walk_seg", seg_a, 7'(d + 1));
            end
            if (frame_a) check("frame_slot0", slot_a, 0);
        end
        for (int d = 0; d < N; d++) check("lit_6_of_8", lit_cnt[d], 6);
        check("frames_per_32", frames, 1);

        // sparse enable 1010: slots 1,3 only
        digit_en = 4'b1010;
        repeat (16) cycle();
        frames = 0;
        bad = 0;
        for (int t = 0; t < 64; t++) begin
            cycle();
            frames += int'(frame_a);
            if (dig_a[0] || dig_a[2]) bad++;
            if (frame_a) check("frame_at_slot1", slot_a, 1);
        end
        check("disabled_never_lit", bad, 0);
        check("frames_per_64", frames, 4);

        // nothing enabled: dark and slot frozen
        digit_en = 4'b0000;
        repeat (4) cycle();
        s0 = int'(slot_a);
        bad = 0;
        frames = 0;
        for (int t = 0; t < 24; t++) begin
            cycle();
            if (dig_a != 4'b0000 || int'(slot_a) != s0) bad++;
            frames += int'(frame_a);
        end
        check("none_en_frozen", bad, 0);
        check("none_en_frames", frames, 0);

        // mid-slot data change is deferred to the next slot of that digit
        digit_en = 4'b1111;
        wait_model(0, 3, 64);
        old_v = seg_in[6:0];
        new_v = old_v ^ 7'(1 + $urandom_range(0, 126));
        set_digit(0, new_v);
        repeat (4) begin
            cycle();
            check("no_tear_lit", dig_a, 4'b0001);
            check("no_tear_seg", seg_a, old_v);
        end
        for (int t = 0; t < 40; t++) begin
            cycle();
            if (dig_a == 4'b0001 && m_slot == 0) check("new_seg_shown", seg_a, new_v);
        end

        // active-low pins for pattern 0x3F on digit 2
        set_digit(2, 7'h3F);
        wait_model(0, 0, 64);
        n = 0;
        cycle();
        while (dig_a != 4'b0100 && n < 40) begin
            cycle();
            n++;
        end
        check("pol_dig_b", dig_b, 4'b1011);
        check("pol_seg_b", seg_b, 7'b1000000);

        // drop on_off mid-slot, then re-raise
        wait_model(1, 4, 64);
        on_off = 1'b0;
        cycle();
        check("off_dig", dig_a, 4'b0000);
        check("off_slot", slot_a, 0);
        repeat (4) cycle();
        on_off = 1'b1;
        n = 0;
        while (dig_a == 4'b0000 && n < 10) begin
            cycle();
            n++;
        end
        check("relit_latency", n, 3);
        check("relit_dig", dig_a, 4'b0001);
        on_off = 1'b0;
        repeat (3) cycle();
        digit_en = 4'b1100;
        on_off = 1'b1;
        cycle();
        check("restart_first_en", slot_a, 2);
        repeat (20) cycle();

        // randomized traffic
        for (int t = 0; t < 500; t++) begin
            if ($urandom_range(0, 19) == 0) digit_en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) set_digit($urandom_range(0, 3), 7'($urandom_range(0, 127)));
            if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom_range(0, 15));
            if (on_off && $urandom_range(0, 59) == 0) on_off = 1'b0;
            else if (!on_off && $urandom_range(0, 5) == 0) on_off = 1'b1;
            cycle();
        end

        // asynchronous reset during lit slot 3
        digit_en = 4'b1111;
        on_off = 1'b1;
        wait_model(3, 4, 80);
        check("pre_rst_lit", dig_a, 4'b1000);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dig_a", dig_a, 4'b0000);
        check("arst_seg_a", seg_a, 7'b0000000);
        check("arst_slot_a", slot_a, 0);
        check("arst_dig_b", dig_b, 4'b1111);
        check("arst_dp_b", dp_b, 1);
        cycle();
        cycle();
        rst_n = 1'b1;
        n = 0;
        while (dig_a == 4'b0000 && n < 10) begin
            cycle();
            n++;
        end
        check("post_rst_latency", n, 3);
        check("post_rst_dig", dig_a, 4'b0001);
        check("post_rst_slot", slot_a, 0);
        repeat (40) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
